// File: rtl/int_cntrl_prio_mask.sv
// rtl/int_cntrl_prio_mask.sv - prioritised, maskable interrupt controller with APB-style register port
// Optional INT_EDGE_MODE_EN adds the EDGE register and per-source rising-edge latching.
module int_cntrl_prio_mask #(
    parameter int NUM_PERIPHS   = 16,
    parameter int PRIO_WIDTH    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int PERIPHS_INDEX = $clog2(NUM_PERIPHS),
    parameter int ADDR_WIDTH    = $clog2(NUM_PERIPHS + 4)
) (
    input  logic                     pclk_i,
    input  logic                     prst_i,
    input  logic [ADDR_WIDTH-1:0]    paddr_i,
    input  logic                     pwrite_i,
    input  logic [DATA_WIDTH-1:0]    pwdata_i,
    input  logic                     penable_i,
    output logic [DATA_WIDTH-1:0]    prdata_o,
    output logic                     pready_o,
    output logic                     perror_o,
    input  logic [NUM_PERIPHS-1:0]   int_active_i,
    input  logic                     int_serviced_i,
    output logic                     int_valid_o,
    output logic [PERIPHS_INDEX-1:0] int_to_service_o,
    output logic [PRIO_WIDTH-1:0]    int_prio_o
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_WAIT_SERVICE = 2'd1;
    localparam logic [1:0] S_COOLDOWN     = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] A_ENABLE  = ADDR_WIDTH'(NUM_PERIPHS);
    localparam logic [ADDR_WIDTH-1:0] A_PENDING = ADDR_WIDTH'(NUM_PERIPHS + 1);
    localparam logic [ADDR_WIDTH-1:0] A_EDGE    = ADDR_WIDTH'(NUM_PERIPHS + 2);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(NUM_PERIPHS + 3);

    logic [PRIO_WIDTH-1:0]    prio_q [NUM_PERIPHS];
    logic [NUM_PERIPHS-1:0]   enable_q;
    logic [NUM_PERIPHS-1:0]   pending;
    logic [NUM_PERIPHS-1:0]   eligible;
    logic [1:0]               state_q;
    logic [PERIPHS_INDEX-1:0] prio_sel;
    logic [PERIPHS_INDEX-1:0] win_idx;
    logic [PRIO_WIDTH-1:0]    win_prio;
    logic                     win_found;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     acc_err;
    logic                     access;
    logic                     wr_ok;
    logic                     svc_done;
    logic                     unused_pwdata;

    assign prio_sel      = paddr_i[PERIPHS_INDEX-1:0];
    assign access        = penable_i && !pready_o;
    assign wr_ok         = access && pwrite_i && !acc_err;
    assign svc_done      = (state_q == S_WAIT_SERVICE) && int_serviced_i;
    assign eligible      = pending & enable_q;
    assign unused_pwdata = ^pwdata_i;

`ifdef INT_EDGE_MODE_EN
    logic [NUM_PERIPHS-1:0] edge_q;
    logic [NUM_PERIPHS-1:0] edge_latch_q;
    logic [NUM_PERIPHS-1:0] prev_q;
    logic [NUM_PERIPHS-1:0] clr_mask;
    logic [NUM_PERIPHS-1:0] latch_next;

    assign pending    = (edge_q & edge_latch_q) | (~edge_q & int_active_i);
    assign clr_mask   = svc_done ? (NUM_PERIPHS'(1) << int_to_service_o) : '0;
    // A fresh edge arriving on the clearing cycle wins over the clear.
    assign latch_next = (edge_latch_q & ~clr_mask) | (int_active_i & ~prev_q & edge_q);

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            edge_q       <= '0;
            edge_latch_q <= '0;
            prev_q       <= '0;
        end else begin
            prev_q <= int_active_i;
            if (wr_ok && paddr_i == A_EDGE) begin
                edge_q       <= pwdata_i[NUM_PERIPHS-1:0];
                edge_latch_q <= latch_next & pwdata_i[NUM_PERIPHS-1:0];
            end else begin
                edge_latch_q <= latch_next;
            end
        end
    end
`else
    assign pending = int_active_i;
`endif

    // Strict '>' while scanning upwards keeps the lowest index on ties.
    always_comb begin
        win_idx   = '0;
        win_prio  = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            if (eligible[i] && (!win_found || prio_q[i] > win_prio)) begin
                win_found = 1'b1;
                win_idx   = PERIPHS_INDEX'(i);
                win_prio  = prio_q[i];
            end
        end
    end

    always_comb begin
        acc_err = 1'b0;
        rd_data = '0;
        if (paddr_i < A_ENABLE) begin
            rd_data = DATA_WIDTH'(prio_q[prio_sel]);
        end else if (paddr_i == A_ENABLE) begin
            rd_data = DATA_WIDTH'(enable_q);
        end else if (paddr_i == A_PENDING) begin
            rd_data = DATA_WIDTH'(pending);
            acc_err = pwrite_i;
        end else if (paddr_i == A_EDGE) begin
`ifdef INT_EDGE_MODE_EN
            rd_data = DATA_WIDTH'(edge_q);
`else
            acc_err = 1'b1;
`endif
        end else if (paddr_i == A_STATUS) begin
            rd_data = DATA_WIDTH'({int_valid_o, int_to_service_o});
            acc_err = pwrite_i;
        end else begin
            acc_err = 1'b1;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            pready_o <= 1'b0;
            perror_o <= 1'b0;
            prdata_o <= '0;
            enable_q <= '1;
            for (int i = 0; i < NUM_PERIPHS; i++) prio_q[i] <= '0;
        end else begin
            pready_o <= access;
            perror_o <= access && acc_err;
            prdata_o <= (access && !pwrite_i && !acc_err) ? rd_data : '0;
            if (wr_ok) begin
                if (paddr_i < A_ENABLE)
                    prio_q[prio_sel] <= pwdata_i[PRIO_WIDTH-1:0];
                else if (paddr_i == A_ENABLE)
                    enable_q <= pwdata_i[NUM_PERIPHS-1:0];
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q          <= S_IDLE;
            int_valid_o      <= 1'b0;
            int_to_service_o <= '0;
            int_prio_o       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        int_valid_o      <= 1'b1;
                        int_to_service_o <= win_idx;
                        int_prio_o       <= win_prio;
                        state_q          <= S_WAIT_SERVICE;
                    end
                end
                S_WAIT_SERVICE: begin
                    if (int_serviced_i) begin
                        int_valid_o      <= 1'b0;
                        int_to_service_o <= '0;
                        int_prio_o       <= '0;
                        state_q          <= S_COOLDOWN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
